uart_tx_arbiter: RTL and testbench

Round-robin scheduler sharing one UART transmitter (trans_fsm datapath) among N_REQ byte producers. It accepts one byte at a time over a valid/ready handshake, presents it on tx_data, and fires the transmitter start strobe. It then tracks the transmitter busy flag through a full frame before granting the next requester. It sits between the system-side producers and the transmitter FSM/shift register.

---
 rtl/uart_tx_arbiter.sv | 78 +++++++
 tb/tb_uart_tx_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among N_REQ byte producers.
// A byte is granted, loaded and started, then the arbiter tracks tx_busy through the frame before the next grant.
module uart_tx_arbiter #(
   parameter int WIDTH   = 8,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 16,
   localparam int GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]       tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic [GW-1:0]          grant_id,
   output logic                   arb_busy,
   output logic                   err_timeout,
   input  logic                   err_clr
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE} state_t;

   state_t        state, nxt;
   logic [GW-1:0] rr_ptr, pick;
   logic [CW-1:0] cnt;
   logic          take, timeout;

   assign take      = state == LOAD && req_valid[grant_id];
   assign timeout   = state == WAIT_ACK && !tx_busy && cnt == CW'(TIMEOUT - 2);
   assign req_ready = (state == LOAD) ? N_REQ'(1) << grant_id : '0;
   assign tx_start  = state != START;
   assign arb_busy  = state != IDLE;

   // walk downward so the lowest offset from rr_ptr is written last and wins
   always_comb begin
      pick = rr_ptr;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (req_valid[(int'(rr_ptr) + i) % N_REQ]) pick = GW'((int'(rr_ptr) + i) % N_REQ);
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = |req_valid ? LOAD : IDLE;
         LOAD:      nxt = take ? START : IDLE;
         START:     nxt = WAIT_ACK;
         WAIT_ACK:  nxt = tx_busy ? WAIT_DONE : timeout ? IDLE : WAIT_ACK;
         WAIT_DONE: nxt = tx_busy ? WAIT_DONE : IDLE;
         default:   nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_data     <= '0;
         grant_id    <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state == IDLE && |req_valid) grant_id <= pick;
         if (take) begin
            tx_data <= req_data[grant_id*WIDTH +: WIDTH];
            rr_ptr  <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
         end
         cnt         <= (state == WAIT_ACK) ? cnt + 1'b1 : '0;
         err_timeout <= timeout | (err_timeout & ~err_clr);
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; the sequencer queues hand-computed grants/bytes, a monitor checks them
// whenever the arbiter raises req_ready or pulls tx_start low.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TO = 16;

   logic          clk, rst, tx_busy, err_clr, tx_start, arb_busy, err_timeout;
   logic [N-1:0]  req_valid, req_ready;
   logic [N*W-1:0] req_data;
   logic [W-1:0]  tx_data;
   logic [1:0]    grant_id;
   logic          model_en;
   int            m_cnt;
   int            cyc = 0;
   int            passed = 0;
   int            total = 0;
   int            rdy_cyc = 0;
   int            st_cyc = 0;
   logic [15:0]   sq[$];
   logic [3:0]    rq[$];
   int            left[N];
   logic [7:0]    nextb[N];

   uart_tx_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
      .arb_busy(arb_busy), .err_timeout(err_timeout), .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // transmitter model: busy rises two cycles after the start strobe and stays high for ten cycles
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_busy <= 1'b0;
         m_cnt   <= 0;
      end else if (model_en && !tx_start) m_cnt <= 1;
      else if (m_cnt != 0) begin
         tx_busy <= (m_cnt < 11);
         m_cnt   <= (m_cnt == 11) ? 0 : m_cnt + 1;
      end
   end

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endfunction

   function automatic void bad(string nm, logic [31:0] act);
      total++;
      $display("FAIL %s: got %0h expected no event", nm, act);
   endfunction

   logic        pb, chk_fall;
   logic [15:0] e;
   always @(negedge clk) begin
      if (!rst) begin
         pb       = 1'b0;
         chk_fall = 1'b0;
      end else begin
         if (req_ready != 0) begin
            if (rq.size() == 0) bad("unexpected_ready", 32'(req_ready));
            else chk("req_ready", 32'(req_ready), 32'(rq.pop_front()));
            rdy_cyc = cyc;
         end
         if (!tx_start) begin
            if (sq.size() == 0) bad("unexpected_start", 32'(tx_data));
            else begin
               e = sq.pop_front();
               chk("tx_data", 32'(tx_data), 32'(e[7:0]));
               chk("grant_id", 32'(grant_id), 32'(e[15:8]));
            end
            chk("start_latency", 32'(cyc - rdy_cyc), 32'd1);
            chk("start_while_busy", 32'(tx_busy), 32'd0);
            st_cyc = cyc;
         end
         if (chk_fall) chk("arb_busy_after_frame", 32'(arb_busy), 32'd0);
         chk_fall = pb && !tx_busy;
         if (chk_fall) chk("arb_busy_at_busy_fall", 32'(arb_busy), 32'd1);
         pb = tx_busy;
      end
   end

   task automatic cycle();
      logic [N-1:0] hs;
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (hs[i]) begin
            if (left[i] > 0) begin
               left[i]--;
               req_data[i*W +: W] = nextb[i];
            end else req_valid[i] = 1'b0;
         end
   endtask

   task automatic run_until_idle(string nm, int budget);
      int n;
      for (n = 0; n < budget; n++) begin
         cycle();
         if (req_valid == 0 && !arb_busy && !tx_busy) break;
      end
      if (n == budget) bad({nm, "_idle_timeout"}, 32'(n));
      repeat (2) cycle();
      chk({nm, "_starts_drained"}, 32'(sq.size()), 32'd0);
      chk({nm, "_readies_drained"}, 32'(rq.size()), 32'd0);
   endtask

   task automatic check_reset();
      chk("rst_tx_start", 32'(tx_start), 32'd1);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_arb_busy", 32'(arb_busy), 32'd0);
      chk("rst_err_timeout", 32'(err_timeout), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench exceeded its time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; req_valid = '0; req_data = '0; err_clr = 1'b0; model_en = 1'b0;
      for (int i = 0; i < N; i++) left[i] = 0;
      for (int i = 0; i < 6; i++) begin
         req_valid = N'($urandom);
         req_data  = ($urandom);
         err_clr   = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check_reset();
      req_valid = '0; req_data = '0; err_clr = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      model_en = 1'b1;
      // single requester
      rq.push_back(4'b0010); sq.push_back({8'd1, 8'hA5});
      req_data[15:8] = 8'hA5; req_valid = 4'b0010;
      run_until_idle("single", 60);
      chk("single_tx_data_hold", 32'(tx_data), 32'hA5);
      chk("single_grant_hold", 32'(grant_id), 32'd1);
      // fairness from a fresh reset: 0,1,2,3 then requester 0's second byte
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      left[0] = 1; nextb[0] = 8'h14;
      req_data = 32'h13121110; req_valid = 4'b1111;
      rq.push_back(4'b0001); rq.push_back(4'b0010); rq.push_back(4'b0100); rq.push_back(4'b1000); rq.push_back(4'b0001);
      sq.push_back({8'd0, 8'h10}); sq.push_back({8'd1, 8'h11}); sq.push_back({8'd2, 8'h12});
      sq.push_back({8'd3, 8'h13}); sq.push_back({8'd0, 8'h14});
      run_until_idle("fair", 200);
      // timeout with a waiting requester 0; rr_ptr is 1 so requester 3 goes first
      model_en = 1'b0;
      req_data = '0; req_data[31:24] = 8'h3C; req_data[7:0] = 8'h5A; req_valid = 4'b1001;
      rq.push_back(4'b1000); rq.push_back(4'b0001);
      sq.push_back({8'd3, 8'h3C}); sq.push_back({8'd0, 8'h5A});
      for (int n = 0; n < 60 && !err_timeout; n++) cycle();
      chk("timeout_err_set", 32'(err_timeout), 32'd1);
      chk("timeout_delay", 32'(cyc - st_cyc), 32'(TO));
      model_en = 1'b1; err_clr = 1'b1;
      cycle();
      chk("timeout_err_clr", 32'(err_timeout), 32'd0);
      err_clr = 1'b0;
      run_until_idle("timeout", 80);
      // set beats clear when both land in the timeout cycle
      model_en = 1'b0; err_clr = 1'b1;
      req_data[15:8] = 8'h77; req_valid = 4'b0010;
      rq.push_back(4'b0010); sq.push_back({8'd1, 8'h77});
      for (int n = 0; n < 60 && !err_timeout; n++) cycle();
      chk("setclr_err_set", 32'(err_timeout), 32'd1);
      chk("setclr_delay", 32'(cyc - st_cyc), 32'(TO));
      cycle();
      chk("setclr_err_cleared_after", 32'(err_timeout), 32'd0);
      err_clr = 1'b0; model_en = 1'b1;
      run_until_idle("setclr", 40);
      // requester 2 withdraws during LOAD; rr_ptr must stay at 2
      rq.push_back(4'b0100);
      req_data[23:16] = 8'h99; req_valid = 4'b0100;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (req_ready != 0) break;
      end
      req_valid[2] = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("drop_grant_id", 32'(grant_id), 32'd2);
      chk("drop_arb_busy", 32'(arb_busy), 32'd0);
      chk("drop_tx_data_hold", 32'(tx_data), 32'h77);
      @(posedge clk);
      #1;
      req_data[15:8] = 8'h21; req_data[23:16] = 8'h22; req_valid = 4'b0110;
      rq.push_back(4'b0100); rq.push_back(4'b0010);
      sq.push_back({8'd2, 8'h22}); sq.push_back({8'd1, 8'h21});
      run_until_idle("drop", 100);
      // reset in WAIT_DONE; rr_ptr (now 2) must return to 0
      req_data[15:8] = 8'h41; req_valid = 4'b0010;
      rq.push_back(4'b0010); sq.push_back({8'd1, 8'h41});
      for (int n = 0; n < 20 && !tx_busy; n++) cycle();
      repeat (3) cycle();
      chk("mid_arb_busy", 32'(arb_busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      check_reset();
      chk("rst_tx_busy_model", 32'(tx_busy), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      req_data[15:8] = 8'h51; req_data[31:24] = 8'h53; req_valid = 4'b1010;
      rq.push_back(4'b0010); rq.push_back(4'b1000);
      sq.push_back({8'd1, 8'h51}); sq.push_back({8'd3, 8'h53});
      run_until_idle("post_reset", 100);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
